// File: rtl/bitmask_encoder_pkg.sv
// -----------------------------------------------------------------------------
// bitmask_encoder_pkg
//
// Shared types and helpers for the bitmask_encoder block.
//   state_t     : encoder FSM state (IDLE waits for a mask, EMIT streams indices)
//   clog2_min1  : ceil(log2(n)), never less than 1, used to size the index port
// -----------------------------------------------------------------------------
package bitmask_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // A mask of width 1 would need a zero-width index, so the result is
  // clamped to 1. The loop is bounded so it stays a simple constant function.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(n)) begin
        r = r + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lsb_find_first_set.sv
// -----------------------------------------------------------------------------
// lsb_find_first_set
//
// Purely combinational lowest-set-bit finder.
//   vec    (in,  WIDTH) : vector to scan
//   idx    (out, IDX_W) : position of the lowest set bit (0 when vec == 0)
//   any    (out, 1)     : OR of all bits of vec
//   single (out, 1)     : exactly one bit of vec is set
// -----------------------------------------------------------------------------
module lsb_find_first_set #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // below_any[gi] is set when some bit strictly below position gi is set,
  // so first_oh keeps only the lowest set bit of vec.
  logic [WIDTH-1:0] below_any;
  logic [WIDTH-1:0] first_oh;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign below_any[gi] = 1'b0;
      end else begin : g_upper
        assign below_any[gi] = |vec[gi-1:0];
      end
      assign first_oh[gi] = vec[gi] & ~below_any[gi];
    end
  endgenerate

  // first_oh is one-hot (or zero), so OR-ing the positions is an encoder.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (first_oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

  assign any    = |vec;
  // Exactly one bit set means the vector equals its own lowest set bit.
  assign single = any && (vec == first_oh);

endmodule

// File: rtl/bitmask_encoder.sv
// -----------------------------------------------------------------------------
// bitmask_encoder
//
// Sequential bit-mask encoder: accepts a WIDTH-bit mask over a valid/ready
// handshake and emits the index of every set bit, lowest first, one index per
// output beat.
//
// Ports:
//   clk       (in,  1)     rising-edge clock
//   rst_n     (in,  1)     synchronous active-low reset
//   in_vec    (in,  WIDTH) mask to encode, sampled only on an input transfer
//   in_valid  (in,  1)     in_vec is valid
//   in_ready  (out, 1)     block can accept in_vec this cycle
//   out_idx   (out, IDX_W) index of the current lowest set bit
//   out_valid (out, 1)     out_idx is valid
//   out_ready (in,  1)     downstream accepts out_idx
//   out_last  (out, 1)     current beat is the final index of this mask
//   zero_err  (out, 1)     one-cycle pulse after an all-zero mask was accepted
//
// Build option:
//   BITMASK_ENCODER_STRICT_ONEHOT_EN - when defined, an accepted mask with more
//   than one bit set is rejected like a zero mask (zero_err pulse, no beats).
// -----------------------------------------------------------------------------
module bitmask_encoder
  import bitmask_encoder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             zero_err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic             zero_err_reg, zero_err_next;

  logic [IDX_W-1:0] mask_idx;
  logic             mask_any;
  logic             mask_single;
  logic             vec_ok;
  logic             emit;
  logic             in_fire;
  logic             out_fire;

  lsb_find_first_set #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_mask_ffs (
    .vec    (mask_reg),
    .idx    (mask_idx),
    .any    (mask_any),
    .single (mask_single)
  );

`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
  logic [IDX_W-1:0] vec_idx;
  logic             vec_any;
  logic             vec_single;

  lsb_find_first_set #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_vec_ffs (
    .vec    (in_vec),
    .idx    (vec_idx),
    .any    (vec_any),
    .single (vec_single)
  );

  // Only one-hot masks are loaded; zero and multi-hot both raise zero_err.
  assign vec_ok = vec_any && vec_single;
`else
  // Any non-zero mask is loaded and serialised.
  assign vec_ok = |in_vec;
`endif

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    zero_err_next = 1'b0;

    // Outputs are gated by rst_n so that asserting reset mid-EMIT stops the
    // stream immediately rather than one edge later.
    emit      = (state_reg == EMIT) && rst_n && mask_any;
    out_valid = emit;
    out_idx   = emit ? mask_idx : '0;
    out_last  = emit && mask_single;
    // On the final beat a new mask may be taken in the same cycle; this is the
    // only path from an input (out_ready) to an output (in_ready).
    in_ready  = rst_n && ((state_reg == IDLE) || (out_last && out_ready));

    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;

    if (out_fire) begin
      // Drop the lowest set bit that was just delivered.
      mask_next = mask_reg & (mask_reg - WIDTH'(1));
      if (out_last) begin
        state_next = IDLE;
      end
    end

    // An input transfer only happens in IDLE or on the final beat, so it
    // always overrides the "return to IDLE" decided above.
    if (in_fire) begin
      if (vec_ok) begin
        mask_next  = in_vec;
        state_next = EMIT;
      end else begin
        zero_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mask_reg     <= '0;
      zero_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      zero_err_reg <= zero_err_next;
    end
  end

  assign zero_err = zero_err_reg;

endmodule

// File: tb/tb_bitmask_encoder.sv
// -----------------------------------------------------------------------------
// tb_bitmask_encoder
//
// Directed testbench for bitmask_encoder (WIDTH=4). Inputs are changed 1 ns
// after a rising edge and outputs are sampled 1 ns later, away from the edge.
// Honours BITMASK_ENCODER_STRICT_ONEHOT_EN for the multi-hot expectations.
// -----------------------------------------------------------------------------
module tb_bitmask_encoder;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             zero_err;

  int checks;
  int errors;

  bitmask_encoder #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock edge and move 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [IDX_W-1:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_vec    = 4'b0101;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    // ---------------- reset held 3 cycles with in_valid high ----------------
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst%0d.in_ready", c),  32'(in_ready),  32'd0);
      chk($sformatf("rst%0d.out_valid", c), 32'(out_valid), 32'd0);
      chk($sformatf("rst%0d.zero_err", c),  32'(zero_err),  32'd0);
    end
    chk("rst.out_idx",  32'(out_idx),  32'd0);
    chk("rst.out_last", 32'(out_last), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    settle();
    expect_idle("rst_release");

    // ---------------- one-hot 0100 ----------------
    in_vec   = 4'b0100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    settle();
    expect_beat("onehot.b0", 2'd2, 1'b1);
    step();
    expect_idle("onehot.done");

    // ---------------- multi-hot 1011 ----------------
    in_vec   = 4'b1011;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    settle();
`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
    chk("multi.zero_err", 32'(zero_err), 32'd1);
    chk("multi.valid",    32'(out_valid), 32'd0);
    step();
    chk("multi.zero_err_end", 32'(zero_err), 32'd0);
    expect_idle("multi.done");
`else
    expect_beat("multi.b0", 2'd0, 1'b0);
    step();
    expect_beat("multi.b1", 2'd1, 1'b0);
    step();
    expect_beat("multi.b3", 2'd3, 1'b1);
    step();
    expect_idle("multi.done");
`endif

    // ---------------- backpressure ----------------
`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
    in_vec = 4'b0010;
`else
    in_vec = 4'b0110;
`endif
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    in_vec   = 4'b1111;  // must be ignored while no transfer happens
    settle();
    for (int c = 0; c < 4; c++) begin
`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
      expect_beat($sformatf("bp.hold%0d", c), 2'd1, 1'b1);
`else
      expect_beat($sformatf("bp.hold%0d", c), 2'd1, 1'b0);
`endif
      chk($sformatf("bp.hold%0d.in_ready", c), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    settle();
`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
    expect_beat("bp.b1", 2'd1, 1'b1);
    step();
`else
    expect_beat("bp.b1", 2'd1, 1'b0);
    step();
    expect_beat("bp.b2", 2'd2, 1'b1);
    step();
`endif
    expect_idle("bp.done");

    // ---------------- zero mask in IDLE ----------------
    in_vec   = 4'b0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    settle();
    chk("zero.zero_err", 32'(zero_err),  32'd1);
    chk("zero.valid",    32'(out_valid), 32'd0);
    step();
    chk("zero.zero_err_end", 32'(zero_err), 32'd0);
    expect_idle("zero.done");

    // ---------------- zero mask offered on a final beat ----------------
    in_vec   = 4'b0001;
    in_valid = 1'b1;
    step();
    in_vec = 4'b0000;
    settle();
    expect_beat("zlast.b0", 2'd0, 1'b1);
    chk("zlast.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    settle();
    chk("zlast.zero_err", 32'(zero_err), 32'd1);
    chk("zlast.valid",    32'(out_valid), 32'd0);
    step();
    chk("zlast.zero_err_end", 32'(zero_err), 32'd0);

    // ---------------- back-to-back, then reset mid-stream ----------------
    in_vec   = 4'b1000;
    in_valid = 1'b1;
    step();
`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
    in_vec = 4'b0010;
`else
    in_vec = 4'b0011;
`endif
    settle();
    expect_beat("b2b.b3", 2'd3, 1'b1);
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    settle();
`ifdef BITMASK_ENCODER_STRICT_ONEHOT_EN
    expect_beat("b2b.b1", 2'd1, 1'b1);
`else
    expect_beat("b2b.b0", 2'd0, 1'b0);
    step();
    expect_beat("b2b.b1pre", 2'd1, 1'b1);
`endif
    rst_n = 1'b0;
    settle();
    chk("midrst.valid",    32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready),  32'd0);
    step();
    chk("midrst.valid_after", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    settle();
    expect_idle("midrst.release");
    step();
    chk("midrst.no_beat", 32'(out_valid), 32'd0);
    chk("midrst.zero_err", 32'(zero_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitmask_encoder.md
Name: bitmask_encoder

Overview:
Sequential encoder, the inverse of the team's 2-to-4 one-hot decoder. It accepts a WIDTH-bit bit-mask over a valid/ready input handshake. It emits the binary index of every set bit, one index per accepted output beat, lowest index first. It sits upstream of the decoder, so decode(encode(x)) reconstructs x one bit per beat.

Parameters:
- WIDTH, 4, bit-mask width; legal range is 2..32.
- IDX_W, $clog2(WIDTH), output index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_vec  input  WIDTH  bit-mask to encode
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept in_vec this cycle
- out_idx  output  IDX_W  index of the current lowest set bit
- out_valid  output  1  out_idx is valid
- out_ready  input  1  downstream accepts out_idx
- out_last  output  1  current beat is the final index of this mask
- zero_err  output  1  one-cycle pulse: an all-zero in_vec was accepted

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-low (rst_n).
- While rst_n=0 at a clk edge, all of the following hold:
  - state=IDLE and mask register=0;
  - out_valid=0, out_idx=0, out_last=0, zero_err=0;
  - in_ready is forced 0 during reset.
- A reset mid-EMIT discards the remaining bits. No further beats are issued.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output beat occurs when out_valid && out_ready.
- States:
  - IDLE: in_ready=1 and out_valid=0.
  - EMIT: out_valid=1.
    - out_idx = position of the lowest set bit of the mask register.
    - out_last = 1 when exactly one bit of the mask register is set.
- Transition IDLE, on an input transfer:
  - in_vec!=0: load mask<=in_vec and go to EMIT.
  - in_vec==0: stay in IDLE and assert zero_err for exactly the next cycle. No output beat is produced.
- Transition EMIT, on an output beat:
  - Clear the lowest set bit of the mask register.
  - If out_last=1, return to IDLE.
- EMIT without out_ready: out_idx, out_last and mask are held stable. out_valid never drops without a beat.
- Back-to-back inputs:
  - In EMIT, in_ready = out_last && out_ready. This is the only combinational input-to-output path.
  - An input transfer coinciding with the final beat loads the new mask directly and stays in EMIT, with no idle bubble.
  - A zero mask arriving there pulses zero_err and goes to IDLE.
- Latency: an input transfer at edge N gives out_valid=1 after edge N.
- Throughput: popcount(in_vec) beats per mask at one beat per cycle.
- in_vec is sampled only on an input transfer. Changes at any other time are ignored.
- out_idx is a zero-extended unsigned index; the MSB position gives WIDTH-1.

Optional Feature:
- Macro: BITMASK_ENCODER_STRICT_ONEHOT_EN.
- Defined:
  - An accepted in_vec with popcount>1 is treated like a zero mask: zero_err pulses and no beats are produced.
  - Every legal mask therefore produces exactly one beat with out_last=1.
- Undefined: multi-hot masks are serialised as described above.

Decomposition:
- Package bitmask_encoder_pkg holds:
  - state enum {IDLE, EMIT};
  - a function clog2_min1 (returns at least 1) used for IDX_W.
- One combinational sub-module, lsb_find_first_set (params WIDTH and IDX_W). It returns:
  - idx, the lowest set bit position;
  - any, the OR of all bits;
  - single, the exact-one-bit flag, also used for out_last and the strict check.
- The state machine, mask register and handshake stay in bitmask_encoder.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0 and zero_err=0 throughout. After release, in_ready=1.
- One-hot: in_vec=4'b0100 with out_ready=1 -> one beat, out_idx=2, out_last=1, then IDLE.
- Multi-hot: in_vec=4'b1011 with out_ready=1 -> beats 0, 1, 3 on consecutive cycles; out_last=1 only on idx 3. With STRICT_ONEHOT_EN defined -> zero_err pulse and no beats.
- Backpressure: in_vec=4'b0110 with out_ready low for 4 cycles -> out_idx=1 held stable with out_valid=1. Raising out_ready -> beats 1, 2.
- Zero mask: in_vec=4'b0000 -> zero_err high for exactly 1 cycle and out_valid stays 0.
- Back-to-back, then reset mid-stream:
  - 4'b1000 then 4'b0011 offered on the final beat -> beats 3, 0, 1 with no bubble.
  - Assert rst_n=0 after beat 0 -> out_valid=0 and no beat 1 is issued.
